// File: rtl/nchu_pkg.sv
// Shared types, default parameters and saturation helper for the LIF layer scheduler.
package nchu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StEmit,
    StDone
  } state_e;

  localparam int unsigned DefW         = 8;
  localparam int          DefThresh    = 2;
  localparam int unsigned DefLeakShift = 1;

  // Clamp a sign-extended value into the signed range of a `width`-bit word (width <= 31).
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int unsigned        width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/neuron_update.sv
// Combinational leaky integrate-and-fire update for one neuron.
module neuron_update
  import nchu_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int          THRESH     = DefThresh,
  parameter int unsigned LEAK_SHIFT = DefLeakShift
) (
  input  logic signed [W-1:0] v_i,
  input  logic signed [W-1:0] in_data_i,
  output logic signed [W-1:0] v_next_o,
  output logic                spike_o
);

  localparam logic signed [W-1:0] ThreshW = W'(THRESH);

  logic signed [W-1:0] leak;
  logic signed [W:0]   sum_wide;
  logic signed [31:0]  sum_sat;
  logic signed [W-1:0] sum;

  // Leak, integrate with one guard bit, saturate, then fire and subtract threshold.
  always_comb begin
    leak     = v_i >>> LEAK_SHIFT;
    sum_wide = {leak[W-1], leak} + {in_data_i[W-1], in_data_i};
    sum_sat  = sat_signed(32'(sum_wide), W);
    sum      = W'(sum_sat);
    spike_o  = (sum >= ThreshW);
    // THRESH > 0 and sum >= THRESH, so the subtraction stays in range.
    v_next_o = spike_o ? (sum - ThreshW) : sum;
  end

endmodule

// File: rtl/nchu_layer_sched.sv
// Time-multiplexed LIF layer scheduler: one shared update path over N_NEURONS membranes.
module nchu_layer_sched
  import nchu_pkg::*;
#(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned W          = DefW,
  parameter int          THRESH     = DefThresh,
  parameter int unsigned LEAK_SHIFT = DefLeakShift,
  parameter int unsigned T_STEPS    = 16,
  localparam int unsigned IdxW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  localparam int unsigned StepW     = (T_STEPS > 1) ? $clog2(T_STEPS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [W-1:0]  in_data_i,
  output logic [IdxW-1:0]      neuron_idx_o,
  output logic [StepW-1:0]     step_idx_o,
  output logic                 spk_valid_o,
  output logic [N_NEURONS-1:0] spk_vec_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_e state_q, state_d;

  logic signed [W-1:0] mem_q [N_NEURONS];
  logic signed [W-1:0] mem_d [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic [N_NEURONS-1:0] spk_vec_q, spk_vec_d;
  logic [IdxW-1:0]      neuron_idx_q, neuron_idx_d;
  logic [StepW-1:0]     step_idx_q, step_idx_d;

  logic                handshake;
  logic                last_neuron;
  logic                last_step;
  logic signed [W-1:0] cur_v;
  logic signed [W-1:0] upd_v;
  logic                upd_spike;

  assign handshake   = in_valid_i & in_ready_o;
  assign last_neuron = (neuron_idx_q == IdxW'(N_NEURONS - 1));
  assign last_step   = (step_idx_q == StepW'(T_STEPS - 1));
  assign cur_v       = mem_q[neuron_idx_q];

  neuron_update #(
    .W         (W),
    .THRESH    (THRESH),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_update (
    .v_i      (cur_v),
    .in_data_i(in_data_i),
    .v_next_o (upd_v),
    .spike_o  (upd_spike)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StClear;
      StClear: state_d = StFetch;
      StFetch: if (handshake && last_neuron) state_d = StEmit;
      StEmit:  state_d = last_step ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from state only; spk_vec shows the fresh vector during the strobe.
  always_comb begin
    in_ready_o   = (state_q == StFetch);
    busy_o       = (state_q != StIdle);
    spk_valid_o  = (state_q == StEmit);
    done_o       = (state_q == StDone);
    spk_vec_o    = (state_q == StEmit) ? acc_q : spk_vec_q;
    neuron_idx_o = neuron_idx_q;
    step_idx_o   = step_idx_q;
  end

  // Datapath next-state: membrane write-back, spike accumulation, index counters.
  always_comb begin
    mem_d        = mem_q;
    acc_d        = acc_q;
    spk_vec_d    = spk_vec_q;
    neuron_idx_d = neuron_idx_q;
    step_idx_d   = step_idx_q;
    unique case (state_q)
      StClear: begin
        for (int i = 0; i < int'(N_NEURONS); i++) begin
          mem_d[i] = '0;
        end
        acc_d        = '0;
        spk_vec_d    = '0;
        neuron_idx_d = '0;
        step_idx_d   = '0;
      end
      StFetch: begin
        if (handshake) begin
          mem_d[neuron_idx_q] = upd_v;
          acc_d[neuron_idx_q] = upd_spike;
          neuron_idx_d        = last_neuron ? '0 : neuron_idx_q + 1'b1;
        end
      end
      StEmit: begin
        spk_vec_d = acc_q;
        acc_d     = '0;
        if (!last_step) begin
          step_idx_d = step_idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        mem_q[i] <= '0;
      end
      acc_q        <= '0;
      spk_vec_q    <= '0;
      neuron_idx_q <= '0;
      step_idx_q   <= '0;
    end else begin
      mem_q        <= mem_d;
      acc_q        <= acc_d;
      spk_vec_q    <= spk_vec_d;
      neuron_idx_q <= neuron_idx_d;
      step_idx_q   <= step_idx_d;
    end
  end

endmodule

// File: tb/tb_nchu_layer_sched.sv
// Randomized self-checking bench for nchu_layer_sched with a step-level LIF reference model.
module tb_nchu_layer_sched;

  localparam int N  = 4;
  localparam int T  = 3;
  localparam int W  = 8;
  localparam int TH = 2;
  localparam int LS = 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [W-1:0] in_data;
  logic [1:0]         neuron_idx;
  logic [1:0]         step_idx;
  logic               spk_valid;
  logic [N-1:0]       spk_vec;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  nchu_layer_sched #(
    .N_NEURONS (N),
    .W         (W),
    .THRESH    (TH),
    .LEAK_SHIFT(LS),
    .T_STEPS   (T)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .neuron_idx_o(neuron_idx),
    .step_idx_o  (step_idx),
    .spk_valid_o (spk_valid),
    .spk_vec_o   (spk_vec),
    .busy_o      (busy),
    .done_o      (done)
  );

  int n_total = 0;
  int n_bad   = 0;

  int data    [T][N];
  int exp_vec [T];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd_range(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  // Expected spike vector of every timestep from plain integer LIF arithmetic.
  function automatic void model();
    int v[N];
    for (int n = 0; n < N; n++) v[n] = 0;
    for (int t = 0; t < T; t++) begin
      exp_vec[t] = 0;
      for (int n = 0; n < N; n++) begin
        int s;
        s = (v[n] >>> LS) + data[t][n];
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (s >= TH) begin
          exp_vec[t] |= (1 << n);
          v[n] = s - TH;
        end else begin
          v[n] = s;
        end
      end
    end
  endfunction

  task automatic build(input int mode);
    for (int t = 0; t < T; t++) begin
      for (int n = 0; n < N; n++) begin
        case (mode)
          1: data[t][n] = 3;
          2: data[t][n] = 1;
          3: data[t][n] = 2;
          4: data[t][n] = (n == 0) ? 127 : (n == 1) ? -128 : rnd_range(-128, 127);
          5: data[t][n] = rnd_range(-4, 6);
          default: data[t][n] = rnd_range(-128, 127);
        endcase
      end
    end
    model();
  endtask

  // One inference; starts and ends on a falling edge. abort_at >= 0 resets at that handshake.
  task automatic run(input int mode, input bit reuse, input int gap_pct, input bit bp,
                     input int abort_at);
    int  cycle;
    int  hs;
    int  steps_seen;
    int  first_rdy;
    int  last_spk;
    int  stall_left;
    bit  stalled;
    bit  done_seen;
    if (!reuse) build(mode);
    hs = 0; steps_seen = 0; first_rdy = -1; last_spk = -100;
    stall_left = 0; stalled = 1'b0; done_seen = 1'b0;
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cycle = 1;
    while (!done_seen && cycle < 400) begin
      if (in_ready && first_rdy < 0) first_rdy = cycle;
      if (abort_at >= 0 && in_ready && hs == abort_at) begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_spk_vec", int'(spk_vec), 0);
        check_eq("abort_done", int'(done), 0);
        check_eq("abort_spk_valid", int'(spk_valid), 0);
        check_eq("abort_in_ready", int'(in_ready), 0);
        check_eq("abort_idx", int'(neuron_idx), 0);
        return;
      end
      if (in_ready) begin
        check_eq("neuron_idx", int'(neuron_idx), hs % N);
        check_eq("step_idx", int'(step_idx), hs / N);
      end
      if (spk_valid) begin
        check_eq("spk_vec", int'(spk_vec), exp_vec[steps_seen % T]);
        check_eq("hs_per_step", hs, N * (steps_seen + 1));
        last_spk = cycle;
        steps_seen++;
      end
      if (done) begin
        done_seen = 1'b1;
        check_eq("step_count", steps_seen, T);
        check_eq("done_after_spk", cycle, last_spk + 1);
        if (gap_pct == 0 && !bp) check_eq("min_len", cycle, 1 + T * (N + 1) + 1);
      end else begin
        start = ($urandom_range(0, 7) == 0);
        if (in_ready) begin
          if (bp && !stalled && (hs % N) == 2) begin
            stall_left = 5;
            stalled    = 1'b1;
          end
          if (stall_left > 0) begin
            in_valid = 1'b0;
            stall_left--;
          end else begin
            in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
          end
          in_data = (hs < T * N) ? W'(data[hs / N][hs % N]) : '0;
        end else begin
          in_valid = 1'($urandom_range(0, 1));
          in_data  = 8'sh7f;
        end
        if (in_valid && in_ready) hs++;
        @(negedge clk);
        cycle++;
      end
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!done_seen) begin
      check_eq("timeout", 0, 1);
    end else begin
      check_eq("first_ready", first_rdy, 2);
      @(negedge clk);
      check_eq("busy_after_done", int'(busy), 0);
      check_eq("spk_vec_hold", int'(spk_vec), exp_vec[T-1]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_spk_valid", int'(spk_valid), 0);
    check_eq("rst_spk_vec", int'(spk_vec), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_idx", int'(neuron_idx), 0);
    check_eq("rst_step", int'(step_idx), 0);
    reset = 1'b0;
    @(negedge clk);

    run(1, 1'b0, 0, 1'b0, -1);       // constant 3: fires every step
    run(2, 1'b0, 0, 1'b0, -1);       // constant 1: never fires
    run(3, 1'b0, 0, 1'b0, -1);       // constant 2: fires, membrane back to 0
    run(4, 1'b0, 20, 1'b0, -1);      // saturation on neurons 0 and 1
    run(0, 1'b0, 30, 1'b1, -1);      // 5-cycle stall at neuron 2
    run(0, 1'b0, 0, 1'b0, N + 2);    // reset mid step 1 at neuron 2
    run(0, 1'b1, 0, 1'b0, -1);       // same data after abort must match a fresh run
    for (int i = 0; i < 6; i++) begin
      run((i % 2 == 0) ? 5 : 0, 1'b0, int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nchu_layer_sched.md
Name: nchu_layer_sched

Overview:
- Time-multiplexed scheduler for one leaky integrate-and-fire neuron update path, shared across N_NEURONS virtual neurons.
- Runs T_STEPS timesteps per inference. In each timestep it requests one MAC result per neuron in index order, updates that neuron's stored membrane, and emits a spike vector at the end of the timestep.
- Sits between the MAC/weight-fetch stage (upstream) and the next layer's spike input (downstream).

Parameters:
- N_NEURONS, 8, virtual neurons sharing the update path (>=2)
- W, 8, signed membrane / MAC width
- THRESH, 2, firing threshold, signed W-bit, >0
- LEAK_SHIFT, 1, arithmetic right-shift applied to the membrane before integration
- T_STEPS, 16, timesteps per inference (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin inference; sampled only in IDLE
- in_valid  in  1  upstream MAC result valid
- in_ready  out  1  scheduler accepts in_data this cycle
- in_data  in  W  signed MAC result for neuron neuron_idx
- neuron_idx  out  clog2(N_NEURONS)  neuron currently requested
- step_idx  out  clog2(T_STEPS)  current timestep
- spk_valid  out  1  one-cycle strobe: spk_vec updated
- spk_vec  out  N_NEURONS  spikes of the completed timestep, bit i = neuron i
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle strobe after the last timestep

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all membranes=0; neuron_idx=0; step_idx=0.
  - spk_vec=0; spk_valid=0; done=0; in_ready=0; busy=0.
  - Reset mid-operation aborts immediately with no spk_valid or done.
- FSM states: IDLE, CLEAR, FETCH, EMIT, DONE.
  - IDLE: start=1 -> CLEAR. start in any other state is ignored.
  - CLEAR (1 cycle): all membranes=0, spk_vec=0, neuron_idx=0, step_idx=0 -> FETCH.
  - FETCH: in_ready=1. Handshake = in_valid & in_ready.
    - No handshake: hold neuron_idx and all state; in_valid while in_ready=0 is ignored.
    - Handshake: update neuron neuron_idx in the same cycle.
    - If neuron_idx < N_NEURONS-1: neuron_idx++ and stay in FETCH. Throughput is 1 neuron/cycle.
    - If neuron_idx == N_NEURONS-1: neuron_idx=0 -> EMIT.
  - EMIT (1 cycle): in_ready=0; spk_vec <= accumulated step spikes; spk_valid=1; clear the step spike accumulator.
    - step_idx == T_STEPS-1 -> DONE.
    - Otherwise step_idx++ -> FETCH.
  - DONE (1 cycle): done=1 -> IDLE. step_idx is held. spk_vec holds until the next EMIT, CLEAR or reset.
- Per-neuron update, combinational within the handshake cycle:
  - Leak: l = V >>> LEAK_SHIFT (arithmetic).
  - Integrate: s = l + in_data, computed in W+1 bits, then saturated to [-2^(W-1), 2^(W-1)-1].
  - Fire: if s >= THRESH (signed compare), spike=1 and V_next = s - THRESH, which cannot underflow.
  - Otherwise spike=0 and V_next = s.
  - The spike bit is written into accumulator bit neuron_idx.
- Latency:
  - start to first in_ready: 2 cycles.
  - Last handshake of a step to spk_valid: 1 cycle.
  - Minimum inference length: 1 + T_STEPS*(N_NEURONS+1) + 1 cycles after start.
- Outputs spk_valid, done and in_ready are registered or decoded from state only. There is no combinational path from in_valid to in_ready.

Decomposition:
- Shared package nchu_pkg holds:
  - state enum {IDLE, CLEAR, FETCH, EMIT, DONE};
  - W, THRESH and LEAK_SHIFT defaults;
  - a saturation function.
- One sub-module, neuron_update: purely combinational. Inputs: V, in_data. Outputs: V_next, spike. It is instantiated once and shared via neuron_idx muxing of the membrane array.

Test Plan (all with N_NEURONS=4, T_STEPS=3, THRESH=2, LEAK_SHIFT=1):
- Constant in_data=3 with in_valid held high -> every step: V 0->3, spike, V=1; next step (1>>>1)+3=3 fires again. spk_vec=4'b1111 on all 3 spk_valid strobes; done 1 cycle after the third.
- in_data=1 for all -> V stays 1 and never reaches 2. spk_vec=4'b0000 each step. in_data=2 -> spike every step with V returning to 0.
- Saturation:
  - Neuron 0 preloaded via steps of in_data=127: step1 V=127-2=125; step2 62+127=189 saturates to 127, spike, V=125.
  - Neuron 1 with in_data=-128 repeatedly: -64-128 saturates to -128, no spike.
- Backpressure: in_valid low for 5 cycles at neuron_idx=2 -> neuron_idx holds at 2, membranes unchanged, no spk_valid. Resumes correctly once in_valid returns high.
- Reset asserted mid step 1 at neuron_idx=2 -> next cycle: IDLE, busy=0, spk_vec=0, no done. A new start then produces results identical to a fresh run.
- start pulsed while busy and in_valid pulsed in EMIT/CLEAR -> both ignored; handshake count per step is exactly 4.
